// File: rtl/cpu_pkg.sv
// Shared definitions for the CPU pipeline control logic: forwarding-mux
// encodings, widths and the shadow-stage record that tracks in-flight writers.
package cpu_pkg;

   localparam int REG_AW = 5;
   localparam int WW_FWD = 2;
   localparam int WW_CNT = 16;

   localparam logic [0:WW_FWD-1] FWD_RF  = 2'b00;
   localparam logic [0:WW_FWD-1] FWD_EX  = 2'b01;
   localparam logic [0:WW_FWD-1] FWD_MEM = 2'b10;
   localparam logic [0:WW_FWD-1] FWD_WB  = 2'b11;

   // One in-flight instruction as seen by the interlock logic.
   typedef struct packed {
      logic              v;
      logic [0:REG_AW-1] rd;
      logic              wr;
      logic              ld;
   } shadow_t;

   // A stage produces the value an operand needs when it holds a real writer
   // of that register and the operand is actually read. r0 is not special.
   function automatic logic producer_match(shadow_t s, logic [0:REG_AW-1] r, logic use_x);
      return s.v && s.wr && (s.rd == r) && use_x;
   endfunction

   // Youngest producer wins; a load still in EX cannot be forwarded, so the
   // selection falls through to the next older producer for that cycle.
   function automatic logic [0:WW_FWD-1] fwd_pick(logic ex_hit, logic ex_ld,
                                                  logic mem_hit, logic wb_hit);
      if (ex_hit && !ex_ld) return FWD_EX;
      if (mem_hit)          return FWD_MEM;
      if (wb_hit)           return FWD_WB;
      return FWD_RF;
   endfunction

endpackage

// File: rtl/hazard_shadow_stage.sv
// One register stage of the shadow pipeline: holds {v, rD, wr, ld} for the
// instruction occupying the matching real pipeline stage.
module hazard_shadow_stage
   import cpu_pkg::*;
(
   input  logic    clk,
   input  logic    reset,
   input  logic    hold_i,
   input  logic    clear_i,
   input  shadow_t d_i,
   output shadow_t q_o
);

   shadow_t stage_q;
   shadow_t stage_d;

   // Hold wins over clear so a frozen pipe keeps its bubbles and writers alike.
   always_comb begin
      stage_d = stage_q;
      if (!hold_i) begin
         stage_d = clear_i ? '0 : d_i;
      end
   end

   // Stage register; reset drops any tracked instruction at once.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) stage_q <= '0;
      else       stage_q <= stage_d;
   end

   assign q_o = stage_q;

endmodule

// File: rtl/hazard_ctrl.sv
// Interlock and forwarding controller for the 5-stage pipeline. Tracks the
// writers in EX/MEM/WB, raises load-use stalls and branch flushes, selects the
// EX operand forwarding sources and counts stall/flush events.
module hazard_ctrl #(
   parameter int REG_AW = 5,
   parameter int CNT_W  = 16
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              ID_valid,
   input  logic [0:REG_AW-1] ID_rA,
   input  logic [0:REG_AW-1] ID_rB,
   input  logic [0:REG_AW-1] ID_rD,
   input  logic              ID_wrEn,
   input  logic              ID_useA,
   input  logic              ID_useB,
   input  logic              ID_isLoad,
   input  logic              EX_brTaken,
   input  logic              mem_busy,
   output logic              stall_IF,
   output logic              stall_ID,
   output logic              bubble_EX,
   output logic              flush_IFID,
   output logic [0:1]        fwdA_sel,
   output logic [0:1]        fwdB_sel,
   output logic [0:CNT_W-1]  stall_cnt,
   output logic [0:CNT_W-1]  flush_cnt
);

   import cpu_pkg::*;

   shadow_t ex_q, mem_q, wb_q, ex_d;
   logic    ex_clear;
   logic    a_ex, a_mem, a_wb, b_ex, b_mem, b_wb;
   logic    load_use, stall_evt, flush_evt;
   logic [0:CNT_W-1] stall_cnt_q, stall_cnt_d, flush_cnt_q, flush_cnt_d;

   assign ex_d     = '{v: 1'b1, rd: ID_rD, wr: ID_wrEn, ld: ID_isLoad};
   assign ex_clear = bubble_EX | flush_IFID | ~ID_valid;

   hazard_shadow_stage u_ex  (.clk(clk), .reset(reset), .hold_i(mem_busy),
                              .clear_i(ex_clear), .d_i(ex_d),  .q_o(ex_q));
   hazard_shadow_stage u_mem (.clk(clk), .reset(reset), .hold_i(mem_busy),
                              .clear_i(1'b0),     .d_i(ex_q),  .q_o(mem_q));
   hazard_shadow_stage u_wb  (.clk(clk), .reset(reset), .hold_i(mem_busy),
                              .clear_i(1'b0),     .d_i(mem_q), .q_o(wb_q));

   assign a_ex  = producer_match(ex_q,  ID_rA, ID_useA);
   assign a_mem = producer_match(mem_q, ID_rA, ID_useA);
   assign a_wb  = producer_match(wb_q,  ID_rA, ID_useA);
   assign b_ex  = producer_match(ex_q,  ID_rB, ID_useB);
   assign b_mem = producer_match(mem_q, ID_rB, ID_useB);
   assign b_wb  = producer_match(wb_q,  ID_rB, ID_useB);

   assign load_use = ID_valid && ex_q.ld && (a_ex || b_ex);

   // Pipe control: a memory freeze dominates, then a taken branch (which makes
   // any stalled ID instruction wrong-path), then the load-use interlock.
   always_comb begin
      stall_IF   = 1'b0;
      stall_ID   = 1'b0;
      bubble_EX  = 1'b0;
      flush_IFID = 1'b0;
      stall_evt  = 1'b0;
      flush_evt  = 1'b0;
      if (mem_busy) begin
         stall_IF = 1'b1;
         stall_ID = 1'b1;
      end else if (EX_brTaken) begin
         flush_IFID = 1'b1;
         bubble_EX  = 1'b1;
         flush_evt  = 1'b1;
      end else if (load_use) begin
         stall_IF  = 1'b1;
         stall_ID  = 1'b1;
         bubble_EX = 1'b1;
         stall_evt = 1'b1;
      end
   end

   // Forwarding selects; an empty ID slot always reads the register file.
   always_comb begin
      fwdA_sel = FWD_RF;
      fwdB_sel = FWD_RF;
      if (ID_valid) begin
         fwdA_sel = fwd_pick(a_ex, ex_q.ld, a_mem, a_wb);
         fwdB_sel = fwd_pick(b_ex, ex_q.ld, b_mem, b_wb);
      end
   end

   // Saturating event counters: they stick at all-ones instead of wrapping.
   always_comb begin
      stall_cnt_d = stall_cnt_q;
      flush_cnt_d = flush_cnt_q;
      if (stall_evt && !(&stall_cnt_q)) stall_cnt_d = stall_cnt_q + CNT_W'(1);
      if (flush_evt && !(&flush_cnt_q)) flush_cnt_d = flush_cnt_q + CNT_W'(1);
   end

   // Counter registers.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         stall_cnt_q <= '0;
         flush_cnt_q <= '0;
      end else begin
         stall_cnt_q <= stall_cnt_d;
         flush_cnt_q <= flush_cnt_d;
      end
   end

   assign stall_cnt = stall_cnt_q;
   assign flush_cnt = flush_cnt_q;

endmodule
